vreg_pipe: RTL and testbench

//  Parametrised successor of the single-cycle 32-bit import-test register.
//  A P_DEPTH-stage delay line, P_NBITS wide, with a per-stage valid bit, a global stall enable,
//  a synchronous flush and a registered occupancy count.

---
 rtl/vreg_pkg.sv | 16 +
 rtl/vreg_stage.sv | 28 ++
 rtl/vreg_pipe.sv | 82 ++++++++
 tb/tb_vreg_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vreg_pkg.sv
// Shared helpers for the vreg_pipe latency element: occupancy width and trace sizing.
package vreg_pkg;

   localparam int unsigned VREG_Q_STR_NBITS = 512*8;

   // Smallest width able to hold the values 0..depth.
   function automatic int unsigned clog2_p1(input int unsigned depth);
      int unsigned w;
      w = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((64'd1 << i) < (64'(depth) + 64'd1)) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/vreg_stage.sv
// One enabled, validated register stage with asynchronous reset.
module vreg_stage #(
   parameter int unsigned          P_NBITS       = 32,
   parameter logic [P_NBITS-1:0]   P_RESET_VALUE = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               clr_val,
   input  logic               in_val,
   input  logic [P_NBITS-1:0] d,
   output logic               out_val,
   output logic [P_NBITS-1:0] q
);

   // Data keeps shifting on en even while clr_val invalidates the stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q       <= P_RESET_VALUE;
         out_val <= 1'b0;
      end else begin
         if (en) q <= d;
         if (clr_val)  out_val <= 1'b0;
         else if (en)  out_val <= in_val;
      end
   end

endmodule

// File: rtl/vreg_pipe.sv
// P_DEPTH-stage delay line with per-stage valid, stall, flush and occupancy count.
module vreg_pipe
   import vreg_pkg::*;
#(
   parameter int unsigned          P_NBITS       = 32,
   parameter int unsigned          P_DEPTH       = 3,
   parameter logic [P_NBITS-1:0]   P_RESET_VALUE = '0
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            en,
   input  logic                            flush,
   input  logic                            in_val,
   input  logic [P_NBITS-1:0]              d,
   output logic [P_NBITS-1:0]              q,
   output logic                            out_val,
   output logic [clog2_p1(P_DEPTH)-1:0]    occupancy
);

   localparam int unsigned OCC_W = clog2_p1(P_DEPTH);

   logic [P_NBITS-1:0] stage_d [P_DEPTH];
   logic [P_NBITS-1:0] stage_q [P_DEPTH];
   logic [P_DEPTH-1:0] val_d;
   logic [P_DEPTH-1:0] val_q;

   for (genvar i = 0; i < P_DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         assign stage_d[i] = d;
         assign val_d[i]   = in_val;
      end else begin : g_body
         assign stage_d[i] = stage_q[i-1];
         assign val_d[i]   = val_q[i-1];
      end

      vreg_stage #(
         .P_NBITS       (P_NBITS),
         .P_RESET_VALUE (P_RESET_VALUE)
      ) u_stage (
         .clk     (clk),
         .reset   (reset),
         .en      (en),
         .clr_val (flush),
         .in_val  (val_d[i]),
         .d       (stage_d[i]),
         .out_val (val_q[i]),
         .q       (stage_q[i])
      );
   end

   assign q       = stage_q[P_DEPTH-1];
   assign out_val = val_q[P_DEPTH-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         occupancy <= '0;
      else if (flush)
         occupancy <= '0;
      else if (en)
         occupancy <= occupancy + OCC_W'(in_val) - OCC_W'(val_q[P_DEPTH-1]);
   end

   a_occ_matches_valids: assert property (@(posedge clk) disable iff (reset)
      occupancy == OCC_W'($countones(val_q)));

   a_ctrl_known: assert property (@(posedge clk) disable iff (reset)
      !$isunknown({en, flush, in_val}));

   // Trace text "<occ>:q = <dec>"; dots of equal width when the output stage is empty.
   function automatic string line_trace();
      localparam logic [P_NBITS-1:0] Q_MAX = '1;
      string mx;
      string s;
      mx = $sformatf("%0d", Q_MAX);
      if (out_val) s = $sformatf("%0d", q);
      else         s = "";
      while (s.len() < mx.len()) s = out_val ? {" ", s} : {s, "."};
      if (s.len() * 8 > int'(VREG_Q_STR_NBITS)) s = s.substr(0, int'(VREG_Q_STR_NBITS) / 8 - 1);
      return $sformatf("%0d:q = %s", occupancy, s);
   endfunction

endmodule

// File: tb/tb_vreg_pipe.sv
// Self-checking bench for vreg_pipe against a history-log reference model.
module tb_vreg_pipe;

   localparam int unsigned D  = 3;
   localparam logic [31:0] RV = 32'hDEAD;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic        flush = 1'b0;
   logic        in_val = 1'b0;
   logic [31:0] d = '0;
   logic [31:0] q;
   logic        out_val;
   logic [1:0]  occ;
   logic [7:0]  q1;
   logic        out_val1;
   logic [0:0]  occ1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vreg_pipe #(.P_NBITS(32), .P_DEPTH(3), .P_RESET_VALUE(32'hDEAD)) dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .in_val(in_val),
      .d(d), .q(q), .out_val(out_val), .occupancy(occ)
   );

   vreg_pipe #(.P_NBITS(8), .P_DEPTH(1), .P_RESET_VALUE(8'h00)) dut1 (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .in_val(in_val),
      .d(d[7:0]), .q(q1), .out_val(out_val1), .occupancy(occ1)
   );

   // Reference: log of items accepted on enabled edges, newest first.
   // The output is whatever was accepted D enabled edges ago; a flush
   // invalidates everything in the log but leaves the data in place.
   typedef struct { logic [31:0] data; logic v; } item_t;
   item_t hist[$];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         hist.delete();
      end else begin
         if (flush) foreach (hist[i]) hist[i].v = 1'b0;
         if (en) begin
            item_t it;
            it.data = d;
            it.v    = in_val && !flush;
            hist.push_front(it);
            while (hist.size() > D) void'(hist.pop_back());
         end
      end
   end

   function automatic logic [31:0] m_q();
      if (hist.size() >= D) return hist[D-1].data;
      return RV;
   endfunction

   function automatic logic m_v();
      if (hist.size() >= D) return hist[D-1].v;
      return 1'b0;
   endfunction

   function automatic logic [1:0] m_occ();
      int n = 0;
      foreach (hist[i]) if (hist[i].v) n++;
      return 2'(n);
   endfunction

   task automatic step(input logic e, input logic f, input logic v, input logic [31:0] dd);
      @(negedge clk);
      en = e; flush = f; in_val = v; d = dd;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++; if (q !== RV || out_val !== 1'b0 || occ !== 2'd0) begin
         failures++; $display("FAIL reset_hold q=%h v=%b occ=%0d want q=%h v=0 occ=0", q, out_val, occ, RV);
      end
      checks++; if (q1 !== 8'h00 || out_val1 !== 1'b0 || occ1 !== 1'b0) begin
         failures++; $display("FAIL reset_hold_d1 q=%h v=%b occ=%0d want 00/0/0", q1, out_val1, occ1);
      end
      @(negedge clk); reset = 1'b0;
      #1;
      checks++; if (q !== RV || out_val !== 1'b0 || occ !== 2'd0) begin
         failures++; $display("FAIL reset_release q=%h v=%b occ=%0d want q=%h v=0 occ=0", q, out_val, occ, RV);
      end
      step(1, 0, 1, 32'hA1); step(1, 0, 1, 32'hA2); step(1, 0, 1, 32'hA3);
      checks++; if (occ !== 2'd3 || out_val !== 1'b1) begin
         failures++; $display("FAIL reset_prefill occ=%0d v=%b want 3/1", occ, out_val);
      end
      @(negedge clk); en = 1'b0; in_val = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++; if (q !== RV || out_val !== 1'b0 || occ !== 2'd0) begin
         failures++; $display("FAIL reset_async q=%h v=%b occ=%0d want q=%h v=0 occ=0", q, out_val, occ, RV);
      end
      @(negedge clk); reset = 1'b0;
      #1;
      checks++; if (q !== RV || out_val !== 1'b0 || occ !== 2'd0) begin
         failures++; $display("FAIL reset_async_release q=%h v=%b occ=%0d want q=%h v=0 occ=0", q, out_val, occ, RV);
      end
   endtask

   task automatic test_stream();
      int   exp_occ [7] = '{1, 2, 3, 3, 2, 1, 0};
      logic exp_v   [7] = '{0, 0, 1, 1, 1, 1, 0};
      for (int i = 0; i < 7; i++) begin
         step(1, 0, i < 4, (i < 4) ? 32'(i + 1) : 32'd0);
         checks++; if (out_val !== exp_v[i] || occ !== 2'(exp_occ[i])) begin
            failures++; $display("FAIL stream_%0d v=%b occ=%0d want v=%b occ=%0d", i, out_val, occ, exp_v[i], exp_occ[i]);
         end
         if (exp_v[i]) begin
            checks++; if (q !== 32'(i - 1)) begin
               failures++; $display("FAIL stream_q_%0d q=%0d want %0d", i, q, i - 1);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] q_h;
      logic [1:0]  occ_h;
      logic        v_h;
      int          n;
      bit          seen99 = 0;
      step(1, 0, 1, 32'd5); step(1, 0, 1, 32'd6);
      q_h = q; occ_h = occ; v_h = out_val;
      checks++; if (occ !== 2'd2) begin
         failures++; $display("FAIL stall_load occ=%0d want 2", occ);
      end
      repeat (2) begin
         step(0, 0, 1, 32'd99);
         checks++; if (q !== q_h || occ !== occ_h || out_val !== v_h) begin
            failures++; $display("FAIL stall_hold q=%0d occ=%0d v=%b want q=%0d occ=%0d v=%b", q, occ, out_val, q_h, occ_h, v_h);
         end
      end
      n = 4;
      while (!(out_val === 1'b1 && q === 32'd5) && n < 12) begin
         step(1, 0, 0, 32'd0);
         n++;
      end
      checks++; if (n != 5) begin
         failures++; $display("FAIL stall_latency edges=%0d want 5", n);
      end
      repeat (3) begin
         step(1, 0, 0, 32'd0);
         if (out_val === 1'b1 && q === 32'd99) seen99 = 1;
         checks++; if (q !== m_q() || out_val !== m_v() || occ !== m_occ()) begin
            failures++; $display("FAIL stall_drain q=%0d v=%b occ=%0d want q=%0d v=%b occ=%0d", q, out_val, occ, m_q(), m_v(), m_occ());
         end
      end
      checks++; if (seen99) begin
         failures++; $display("FAIL stall_99 seen=1 want 0");
      end
   endtask

   task automatic test_flush();
      step(1, 0, 1, 32'd20); step(1, 0, 1, 32'd21); step(1, 0, 1, 32'd22);
      checks++; if (occ !== 2'd3) begin
         failures++; $display("FAIL flush_fill occ=%0d want 3", occ);
      end
      step(1, 1, 1, 32'd7);
      checks++; if (occ !== 2'd0 || out_val !== 1'b0) begin
         failures++; $display("FAIL flush_now occ=%0d v=%b want 0/0", occ, out_val);
      end
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 32'd0);
         checks++; if (out_val !== 1'b0 || occ !== 2'd0) begin
            failures++; $display("FAIL flush_after_%0d v=%b q=%0d occ=%0d want v=0 occ=0", i, out_val, q, occ);
         end
      end
   endtask

   task automatic test_bubbles();
      logic        pv   [6] = '{1, 0, 1, 0, 0, 0};
      logic [31:0] pd   [6] = '{10, 11, 12, 0, 0, 0};
      logic        ev   [6] = '{0, 0, 1, 0, 1, 0};
      int          eocc [6] = '{1, 1, 2, 1, 1, 0};
      for (int i = 0; i < 6; i++) begin
         step(1, 0, pv[i], pd[i]);
         checks++; if (out_val !== ev[i] || occ !== 2'(eocc[i])) begin
            failures++; $display("FAIL bubble_%0d v=%b occ=%0d want v=%b occ=%0d", i, out_val, occ, ev[i], eocc[i]);
         end
         if (ev[i]) begin
            checks++; if (q !== ((i == 2) ? 32'd10 : 32'd12)) begin
               failures++; $display("FAIL bubble_q_%0d q=%0d want %0d", i, q, (i == 2) ? 10 : 12);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'($urandom), $urandom);
         checks++; if (q !== m_q() || out_val !== m_v() || occ !== m_occ()) begin
            failures++; $display("FAIL random_%0d q=%h v=%b occ=%0d want q=%h v=%b occ=%0d", i, q, out_val, occ, m_q(), m_v(), m_occ());
         end
      end
   endtask

   task automatic test_depth1();
      string tr;
      step(1, 0, 1, 32'h000000FF);
      tr = dut1.line_trace();
      checks++; if (q1 !== 8'hFF || out_val1 !== 1'b1 || occ1 !== 1'b1) begin
         failures++; $display("FAIL depth1_load q=%h v=%b occ=%0d want ff/1/1", q1, out_val1, occ1);
      end
      checks++; if (tr != "1:q = 255") begin
         failures++; $display("FAIL depth1_trace got '%s' want '1:q = 255'", tr);
      end
      step(0, 0, 0, 32'h0);
      checks++; if (q1 !== 8'hFF || out_val1 !== 1'b1) begin
         failures++; $display("FAIL depth1_stall q=%h v=%b want ff/1", q1, out_val1);
      end
      step(1, 0, 0, 32'h3C);
      tr = dut1.line_trace();
      checks++; if (q1 !== 8'h3C || out_val1 !== 1'b0 || tr != "0:q = ...") begin
         failures++; $display("FAIL depth1_empty q=%h v=%b trace '%s' want 3c/0 '0:q = ...'", q1, out_val1, tr);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_bubbles();
      test_random();
      test_depth1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
